ymp_alu_matrix: RTL and testbench
=================================

Name: ymp_alu_matrix

Overview:
- Element-wise vector/matrix ALU peripheral.
- Receives operand matrix A, then operand matrix B, as two AXI-Stream packets, each element one AXI_DATA_W word.
- Applies the operation selected over APB and streams the result matrix out as one AXI-Stream packet.
- Raises a level interrupt on completion or error.
- Sits on the SoC APB config bus, between a stream source and a stream sink.

Parameters:
- AXI_DATA_W, 32, element/data width of both streams.
- BUFFER_DEPTH, 16, maximum elements per operand matrix (power of 2, ≤255).

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- irq_o  out  1  interrupt, level: |(IRQ_STAT & IRQ_EN).
- paddr_i  in  8  APB byte address.
- pwdata_i  in  32  APB write data.
- prdata_o  out  32  APB read data.
- penable_i  in  1  APB access phase (no psel; access whenever penable_i=1).
- pwrite_i  in  1  1=write.
- pready_o  out  1  always 1 (zero wait states).
- pslverr_o  out  1  1 during access to an unmapped address.
- axis_data_i  in  AXI_DATA_W  input element.
- axis_valid_i  in  1  input valid.
- axis_ready_o  out  1  input ready.
- axis_last_i  in  1  last element of the current operand packet.
- axis_data_o  out  AXI_DATA_W  result element.
- axis_valid_o  out  1  output valid.
- axis_ready_i  in  1  downstream ready.
- axis_last_o  out  1  last result element.

Behaviour:
- Reset: all registers 0; state IDLE; irq_o, axis_ready_o, axis_valid_o, axis_last_o, pslverr_o, prdata_o = 0; pready_o = 1.
- APB: write takes effect on the clock edge where penable_i & pwrite_i. prdata_o is combinational from paddr_i when penable_i & !pwrite_i, else 0.
- Register map:
  - 0x00 CTRL: [0] START (write 1 = pulse, reads 0); [3:1] OP.
  - 0x04 STATUS (RO): [0] BUSY; [1] DONE; [2] ERR; [15:8] LEN.
  - 0x08 IRQ_STAT: [0] done, [1] err; write 1 clears the bit.
  - 0x0C IRQ_EN: [1:0].
  - Any other address: pslverr_o=1, writes ignored.
- OP encoding: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 MUL (low AXI_DATA_W bits), 6 MIN (signed), 7 MAX (signed). ADD/SUB wrap modulo 2^AXI_DATA_W.
- FSM states: IDLE, LOAD_A, LOAD_B, SEND.
- IDLE: START moves to LOAD_A and clears DONE/ERR and LEN. OP is latched at START. START while BUSY is ignored.
- LOAD_A: axis_ready_o=1. Each handshake writes buf_a[idx] and increments idx. On last, LEN=idx+1 and the FSM enters LOAD_B. A beat with idx==BUFFER_DEPTH is an overflow error.
- LOAD_B: axis_ready_o=1. Beats go to buf_b. last must arrive exactly on beat LEN; early or late last is an error. On a good last the FSM enters SEND.
- SEND: axis_valid_o=1 and axis_data_o = op(buf_a[k], buf_b[k]), registered. k advances on valid&ready. axis_last_o=1 when k==LEN-1. Data is held stable while ready=0. After the last handshake: DONE=1, IRQ_STAT[0]=1, return to IDLE.
- Latency: first output valid 1 cycle after the LOAD_B last handshake. Throughput 1 element/cycle.
- Error handling: set ERR and IRQ_STAT[1]. Keep axis_ready_o=1 and discard beats until the offending packet's last (for late last or overflow), then IDLE. No output packet is produced.
- Reset mid-operation: aborts immediately to IDLE; no partial output completes.
- Simultaneous hardware set and APB write-1-clear of the same IRQ_STAT bit: set wins.

Optional Feature:
- Macro ALU_MATRIX_SATURATE_EN.
- Defined: ADD/SUB saturate signed, to 0x7FFF_FFFF / 0x8000_0000 for W=32. STATUS[3] reads 1.
- Undefined: ADD/SUB wrap; STATUS[3] reads 0.

Test Plan:
- Reset check: reset_i pulse → STATUS=0, irq_o=0, axis_ready_o=0, read of 0x10 gives pslverr_o=1.
- ADD, LEN=4: write IRQ_EN=1, CTRL=0x01. A={1,2,3,4}, B={10,20,30,40} → output {11,22,33,44}, last on 4th element, STATUS DONE=1 LEN=4, irq_o=1. Write IRQ_STAT=1 → irq_o=0.
- SUB with backpressure: A={5}, B={7}, OP=1, axis_ready_i toggling → output 0xFFFFFFFE (wrap) held stable until accepted, last=1.
- XOR/MAX, LEN=BUFFER_DEPTH, random data → outputs match the golden model.
- Length mismatch: A has 3 elements, B has last on element 2 → ERR=1, IRQ_STAT[1]=1, no output valid, FSM back to IDLE.
- Overflow: A has 17 beats without last → ERR=1; the next START with a good packet completes normally.

Source files
------------

// File: rtl/ymp_alu_matrix.sv
// Element-wise matrix ALU: operand A then B arrive as AXI-Stream packets, result leaves as one packet.
// Define ALU_MATRIX_SATURATE_EN for signed-saturating ADD/SUB (STATUS[3] then reads 1).
module ymp_alu_matrix #(
    parameter int AXI_DATA_W   = 32,
    parameter int BUFFER_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  irq_o,
    input  logic [7:0]            paddr_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [AXI_DATA_W-1:0] axis_data_i,
    input  logic                  axis_valid_i,
    output logic                  axis_ready_o,
    input  logic                  axis_last_i,
    output logic [AXI_DATA_W-1:0] axis_data_o,
    output logic                  axis_valid_o,
    input  logic                  axis_ready_i,
    output logic                  axis_last_o
);
    localparam int W  = AXI_DATA_W;
    localparam int AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam logic [7:0] DEPTH = 8'(BUFFER_DEPTH);
`ifdef ALU_MATRIX_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, SEND} state_t;

    state_t         state_q, state_d;
    logic [7:0]     idx_q, idx_d, len_q, len_d, k_q, k_d;
    logic           drain_q, drain_d;
    logic [2:0]     ctrl_op_q, ctrl_op_d, op_q, op_d;
    logic           done_q, done_d, err_q, err_d;
    logic [1:0]     irq_stat_q, irq_stat_d, irq_en_q, irq_en_d;
    logic [W-1:0]   od_q, od_d;
    logic           ov_q, ov_d, ol_q, ol_d;
    logic           set_done, set_err;
    logic [1:0]     clr;

    logic [W-1:0]   buf_a [BUFFER_DEPTH];
    logic [W-1:0]   buf_b [BUFFER_DEPTH];

    logic           apb_wr, apb_rd, addr_hit, start, in_hs;
    logic [7:0]     nxt;
    logic [W-1:0]   opa, opb;

    function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        s = (op == 3'd1) ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
        case (op)
            3'd0, 3'd1: begin
`ifdef ALU_MATRIX_SATURATE_EN
                // Sign-extended sum disagreeing in its top two bits means signed overflow.
                if (s[W] != s[W-1]) r = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                else                r = s[W-1:0];
`else
                r = s[W-1:0];
`endif
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a * b;
            3'd6:    r = ($signed(a) < $signed(b)) ? a : b;
            default: r = ($signed(a) > $signed(b)) ? a : b;
        endcase
        return r;
    endfunction

    assign apb_wr       = penable_i & pwrite_i;
    assign apb_rd       = penable_i & ~pwrite_i;
    assign addr_hit     = (paddr_i == 8'h00) || (paddr_i == 8'h04) || (paddr_i == 8'h08) || (paddr_i == 8'h0C);
    assign start        = apb_wr && (paddr_i == 8'h00) && pwdata_i[0];
    assign axis_ready_o = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign in_hs        = axis_ready_o & axis_valid_i;
    assign pready_o     = 1'b1;
    assign pslverr_o    = penable_i & ~addr_hit;
    assign irq_o        = |(irq_stat_q & irq_en_q);
    assign axis_data_o  = od_q;
    assign axis_valid_o = ov_q;
    assign axis_last_o  = ol_q;

    always_comb begin
        prdata_o = '0;
        if (apb_rd) begin
            case (paddr_i)
                8'h00:   prdata_o = {28'd0, ctrl_op_q, 1'b0};
                8'h04:   prdata_o = {16'd0, len_q, 4'd0, SAT, err_q, done_q, state_q != IDLE};
                8'h08:   prdata_o = {30'd0, irq_stat_q};
                8'h0C:   prdata_o = {30'd0, irq_en_q};
                default: prdata_o = '0;
            endcase
        end
    end

    // The first result is computed while the last B beat is still on the bus, so it
    // bypasses the buffer when LEN is 1.
    always_comb begin
        nxt = (state_q == LOAD_B) ? 8'd0 : k_q + 8'd1;
        opa = buf_a[nxt[AW-1:0]];
        opb = (state_q == LOAD_B && idx_q == 8'd0) ? axis_data_i : buf_b[nxt[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (in_hs && !drain_q && idx_q < DEPTH) begin
            if (state_q == LOAD_A) buf_a[idx_q[AW-1:0]] <= axis_data_i;
            else                   buf_b[idx_q[AW-1:0]] <= axis_data_i;
        end
    end

    always_comb begin
        state_d = state_q;  idx_d = idx_q;  len_d = len_q;  k_d = k_q;  drain_d = drain_q;
        ctrl_op_d = ctrl_op_q;  op_d = op_q;  done_d = done_q;  err_d = err_q;
        irq_en_d = irq_en_q;  od_d = od_q;  ov_d = ov_q;  ol_d = ol_q;
        set_done = 1'b0;  set_err = 1'b0;  clr = 2'b00;
        if (apb_wr) begin
            case (paddr_i)
                8'h00:   ctrl_op_d = pwdata_i[3:1];
                8'h08:   clr = pwdata_i[1:0];
                8'h0C:   irq_en_d = pwdata_i[1:0];
                default: ;
            endcase
        end
        if (in_hs && drain_q) begin
            // Errored packet: swallow beats until its last.
            if (axis_last_i) begin
                state_d = IDLE;
                drain_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = LOAD_A;  op_d = pwdata_i[3:1];
                    done_d = 1'b0;  err_d = 1'b0;  len_d = '0;  idx_d = '0;  drain_d = 1'b0;
                end
                LOAD_A: if (in_hs) begin
                    if (idx_q == DEPTH) begin
                        set_err = 1'b1;
                        if (axis_last_i) state_d = IDLE;
                        else             drain_d = 1'b1;
                    end else if (axis_last_i) begin
                        len_d = idx_q + 8'd1;  idx_d = '0;  state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                LOAD_B: if (in_hs) begin
                    if (idx_q != len_q - 8'd1) begin
                        if (axis_last_i) begin
                            set_err = 1'b1;  state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end else if (axis_last_i) begin
                        state_d = SEND;  k_d = '0;
                        ov_d = 1'b1;  od_d = alu(op_q, opa, opb);  ol_d = (len_q == 8'd1);
                    end else begin
                        set_err = 1'b1;  drain_d = 1'b1;
                    end
                end
                SEND: if (axis_ready_i) begin
                    if (ol_q) begin
                        ov_d = 1'b0;  ol_d = 1'b0;  done_d = 1'b1;  set_done = 1'b1;  state_d = IDLE;
                    end else begin
                        k_d = k_q + 8'd1;  od_d = alu(op_q, opa, opb);  ol_d = (k_q + 8'd2 == len_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (set_err) err_d = 1'b1;
        irq_stat_d = (irq_stat_q & ~clr) | {set_err, set_done};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;  idx_q <= '0;  len_q <= '0;  k_q <= '0;  drain_q <= 1'b0;
            ctrl_op_q <= '0;  op_q <= '0;  done_q <= 1'b0;  err_q <= 1'b0;
            irq_stat_q <= '0;  irq_en_q <= '0;  od_q <= '0;  ov_q <= 1'b0;  ol_q <= 1'b0;
        end else begin
            state_q <= state_d;  idx_q <= idx_d;  len_q <= len_d;  k_q <= k_d;  drain_q <= drain_d;
            ctrl_op_q <= ctrl_op_d;  op_q <= op_d;  done_q <= done_d;  err_q <= err_d;
            irq_stat_q <= irq_stat_d;  irq_en_q <= irq_en_d;  od_q <= od_d;  ov_q <= ov_d;  ol_q <= ol_d;
        end
    end
endmodule

// File: tb/tb_ymp_alu_matrix.sv
// Scoreboard bench for ymp_alu_matrix: expected results queued at issue, popped by an output monitor.
module tb_ymp_alu_matrix;
    localparam int W = 32;
    localparam int D = 16;
`ifdef ALU_MATRIX_SATURATE_EN
    localparam logic [31:0] SATB = 32'h8;
`else
    localparam logic [31:0] SATB = 32'h0;
`endif
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic          clk, reset_i, irq_o;
    logic [7:0]    paddr_i;
    logic [31:0]   pwdata_i, prdata_o;
    logic          penable_i, pwrite_i, pready_o, pslverr_o;
    logic [W-1:0]  axis_data_i, axis_data_o;
    logic          axis_valid_i, axis_ready_o, axis_last_i;
    logic          axis_valid_o, axis_ready_i, axis_last_o;

    int            n_chk = 0, n_fail = 0, out_cnt = 0;
    logic [W:0]    exp_q[$];
    logic [W-1:0]  beats[$], qa[$], qb[$];
    logic          bp_en = 1'b0;

    ymp_alu_matrix #(.AXI_DATA_W(W), .BUFFER_DEPTH(D)) dut (
        .clk_i(clk), .reset_i(reset_i), .irq_o(irq_o),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
        .penable_i(penable_i), .pwrite_i(pwrite_i), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .axis_data_i(axis_data_i), .axis_valid_i(axis_valid_i), .axis_ready_o(axis_ready_o),
        .axis_last_i(axis_last_i), .axis_data_o(axis_data_o), .axis_valid_o(axis_valid_o),
        .axis_ready_i(axis_ready_i), .axis_last_o(axis_last_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0, 1: begin
                s = (op == 0) ? sa + sb : sa - sb;
`ifdef ALU_MATRIX_SATURATE_EN
                if (s > SMAX) s = SMAX;
                else if (s < SMIN) s = SMIN;
`endif
                return s[31:0];
            end
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            6: return (sa < sb) ? a : b;
            default: return (sa > sb) ? a : b;
        endcase
    endfunction

    // Downstream ready: random under backpressure, else always ready.
    initial begin
        axis_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            axis_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pops on every handshake, checks hold-stability under stall.
    initial begin
        logic        stall;
        logic [W:0]  held, e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                stall = 1'b0;
            end else if (axis_valid_o) begin
                out_cnt++;
                if (stall) chk("out_held_stable", axis_data_o, held[W-1:0]);
                if (axis_ready_i) begin
                    stall = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("out_unexpected_valid", 32'(axis_valid_o), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", axis_data_o, e[W-1:0]);
                        chk("out_last", 32'(axis_last_o), 32'(e[W]));
                    end
                end else begin
                    stall = 1'b1;
                    held  = {axis_last_o, axis_data_o};
                end
            end else if (stall) begin
                chk("out_valid_dropped", 32'(axis_valid_o), 32'd1);
                stall = 1'b0;
            end
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        paddr_i = a; pwdata_i = d; pwrite_i = 1'b1; penable_i = 1'b1;
        @(posedge clk); #1;
        penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        paddr_i = a; pwrite_i = 1'b0; penable_i = 1'b1;
        @(negedge clk);
        d = prdata_o;
        e = pslverr_o;
        @(posedge clk); #1;
        penable_i = 1'b0;
    endtask

    task automatic send_beats(input int last_at);
        logic hs;
        int   n;
        foreach (beats[i]) begin
            axis_data_i = beats[i]; axis_valid_i = 1'b1; axis_last_i = (i == last_at);
            n = 0;
            do begin
                @(negedge clk); hs = axis_ready_o;
                @(posedge clk); #1; n++;
            end while (!hs && n < 50);
            if (!hs) begin
                chk("in_handshake_timeout", 32'(hs), 32'd1);
                break;
            end
        end
        axis_valid_i = 1'b0; axis_last_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] rd;
        logic        er;
        int          n;
        n = 0;
        do begin
            apb_read(8'h04, rd, er); n++;
        end while (rd[0] && n < 300);
        chk("idle_timeout", 32'(rd[0]), 32'd0);
    endtask

    task automatic run_op(input int op, input int len, input logic bp);
        logic [31:0] rd;
        logic        er;
        for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, model(op, qa[i], qb[i])});
        apb_write(8'h00, 32'(op * 2 + 1));
        beats = qa; send_beats(len - 1);
        bp_en = bp;
        beats = qb; send_beats(len - 1);
        @(negedge clk);
        chk("first_valid_latency", 32'(axis_valid_o), 32'd1);
        @(posedge clk); #1;
        wait_idle();
        bp_en = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        apb_read(8'h04, rd, er);
        chk("status_done", rd, 32'h2 | SATB | 32'(len << 8));
    endtask

    task automatic fill_rand(input int len);
        qa.delete(); qb.delete();
        for (int i = 0; i < len; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          oc, len, op;
        reset_i = 1'b1; paddr_i = '0; pwdata_i = '0; penable_i = 1'b0; pwrite_i = 1'b0;
        axis_data_i = '0; axis_valid_i = 1'b0; axis_last_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;

        // Reset state
        apb_read(8'h04, rd, er);
        chk("reset_status", rd, SATB);
        chk("reset_status_slverr", 32'(er), 32'd0);
        chk("reset_irq", 32'(irq_o), 32'd0);
        chk("reset_in_ready", 32'(axis_ready_o), 32'd0);
        chk("reset_out_valid", 32'(axis_valid_o), 32'd0);
        chk("pready", 32'(pready_o), 32'd1);
        apb_read(8'h10, rd, er);
        chk("unmapped_slverr", 32'(er), 32'd1);
        chk("unmapped_rdata", rd, 32'd0);

        // ADD, LEN=4, done interrupt
        apb_write(8'h0C, 32'h1);
        qa = '{32'd1, 32'd2, 32'd3, 32'd4};
        qb = '{32'd10, 32'd20, 32'd30, 32'd40};
        run_op(0, 4, 1'b0);
        chk("add_irq_set", 32'(irq_o), 32'd1);
        apb_write(8'h08, 32'h1);
        chk("add_irq_cleared", 32'(irq_o), 32'd0);

        // SUB with backpressure: 5 - 7 wraps to 0xFFFFFFFE
        qa = '{32'd5};
        qb = '{32'd7};
        run_op(1, 1, 1'b1);

        // XOR and MAX at full depth, then random ops/lengths
        fill_rand(D); run_op(4, D, 1'b0);
        fill_rand(D); run_op(7, D, 1'b1);
        for (int it = 0; it < 6; it++) begin
            op  = $urandom_range(0, 7);
            len = $urandom_range(1, D);
            fill_rand(len);
            if (it == 0) begin qa[0] = 32'h7FFF_FFF0; qb[0] = 32'h0000_0100; op = 0; end
            run_op(op, len, 1'($urandom_range(0, 1)));
        end

        // Early last on B
        apb_write(8'h0C, 32'h3);
        apb_write(8'h08, 32'h3);
        oc = out_cnt;
        apb_write(8'h00, 32'h1);
        beats = '{32'd1, 32'd2, 32'd3}; send_beats(2);
        beats = '{32'd4, 32'd5};        send_beats(1);
        repeat (3) @(posedge clk); #1;
        apb_read(8'h04, rd, er);
        chk("early_last_status", rd, 32'h304 | SATB);
        apb_read(8'h08, rd, er);
        chk("early_last_irq_stat", rd, 32'h2);
        chk("early_last_irq", 32'(irq_o), 32'd1);
        chk("early_last_no_output", 32'(out_cnt), 32'(oc));

        // Late last on B
        apb_write(8'h08, 32'h3);
        apb_write(8'h00, 32'h1);
        beats = '{32'd1, 32'd2};        send_beats(1);
        beats = '{32'd4, 32'd5, 32'd6}; send_beats(2);
        apb_read(8'h04, rd, er);
        chk("late_last_status", rd, 32'h204 | SATB);
        chk("late_last_no_output", 32'(out_cnt), 32'(oc));

        // Overflow: 17 beats without last, then the terminating beat
        apb_write(8'h08, 32'h3);
        apb_write(8'h00, 32'h1);
        beats.delete();
        for (int i = 0; i < D + 1; i++) beats.push_back(32'(i));
        send_beats(-1);
        apb_read(8'h04, rd, er);
        chk("overflow_status_draining", rd, 32'h5 | SATB);
        beats = '{32'd99}; send_beats(0);
        apb_read(8'h04, rd, er);
        chk("overflow_status_idle", rd, 32'h4 | SATB);
        apb_read(8'h08, rd, er);
        chk("overflow_irq_stat", rd, 32'h2);
        chk("overflow_no_output", 32'(out_cnt), 32'(oc));
        fill_rand(3); run_op(2, 3, 1'b0);

        // Reset in the middle of loading A
        apb_write(8'h00, 32'h7);
        beats = '{32'd1, 32'd2}; send_beats(-1);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        apb_read(8'h04, rd, er);
        chk("midreset_status", rd, SATB);
        chk("midreset_in_ready", 32'(axis_ready_o), 32'd0);
        chk("midreset_irq", 32'(irq_o), 32'd0);
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
